// File: rtl/sigmoid_vec_ctrl.sv
// Requester side of the sigmoidfn cs_s/rdy_s handshake: streams a buffered
// vector of Q3.12 pre-activations through sigmoidfn and collects the results.
module sigmoid_vec_ctrl #(
   parameter int N_ELEM  = 8,
   parameter int AW      = 3,
   parameter int TIMEOUT = 64
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [15:0]   wr_data,
   input  logic          start,
   input  logic [AW-1:0] rd_addr,
   output logic [15:0]   rd_data,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic          cs_s,
   output logic [15:0]   y,
   input  logic [15:0]   Out,
   input  logic          rdy_s
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, REQ, GAP, DONE} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   idx_q, idx_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            err_q, err_d;
   logic [15:0]     rd_data_q;
   logic [15:0]     inbuf_q [0:(1<<AW)-1];
   logic [15:0]     res_q   [0:(1<<AW)-1];
   logic            last_elem;
   logic            timeout_hit;
   logic            run_active;

   assign last_elem   = (idx_q == AW'(N_ELEM - 1));
   assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));
   assign run_active  = (state_q == REQ) || (state_q == GAP);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // A rdy_s arriving on the last allowed REQ cycle takes priority over the timeout.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = REQ;
         REQ: begin
            if (rdy_s)            state_d = last_elem ? DONE : GAP;
            else if (timeout_hit) state_d = DONE;
         end
         GAP:     state_d = REQ;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      idx_d = idx_q;
      cnt_d = cnt_q;
      err_d = err_q;
      if (state_q == IDLE && start) begin
         idx_d = '0;
         cnt_d = '0;
         err_d = 1'b0;
      end else if (state_q == REQ) begin
         if (rdy_s) begin
            cnt_d = '0;
            if (!last_elem) idx_d = idx_q + AW'(1);
         end else if (timeout_hit) begin
            cnt_d = '0;
            err_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_comb begin
      cs_s    = (state_q == REQ);
      busy    = run_active;
      done    = (state_q == DONE);
      err     = err_q;
      rd_data = rd_data_q;
      y       = (state_q == REQ) ? inbuf_q[idx_q] : 16'h0000;
   end

   // Input buffer is frozen while a run is in flight; results land only on a REQ handshake.
   always_ff @(posedge clk) begin
      if (wr_en && !run_active) inbuf_q[wr_addr] <= wr_data;
      if (state_q == REQ && rdy_s) res_q[idx_q] <= Out;
   end

   always_ff @(posedge clk) begin
      if (rst) rd_data_q <= 16'h0000;
      else     rd_data_q <= res_q[rd_addr];
   end

endmodule

// File: tb/tb_sigmoid_vec_ctrl.sv
// Directed bench for sigmoid_vec_ctrl with a hand-driven sigmoidfn responder.
module tb_sigmoid_vec_ctrl;

   logic        clk = 1'b0;
   logic        rst, wr_en, start, rdy_s;
   logic [1:0]  wr_addr, rd_addr;
   logic [15:0] wr_data, Out;
   logic [15:0] rd_data, y;
   logic        busy, done, err, cs_s;
   int          total = 0;
   int          passed = 0;

   sigmoid_vec_ctrl #(.N_ELEM(3), .AW(2), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .start(start), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy),
      .done(done), .err(err), .cs_s(cs_s), .y(y), .Out(Out), .rdy_s(rdy_s)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic load(input logic [1:0] a, input logic [15:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Serve one element: cs_s must stay high with stable y for lat cycles, rdy_s on the last.
   task automatic serve(input int lat, input logic [15:0] ey, input logic [15:0] val,
                        input bit last, input bit inj);
      for (int i = 1; i <= lat; i++) begin
         chk("cs_in_req", {15'd0, cs_s}, 16'd1);
         chk("y_in_req", y, ey);
         if (inj && i == 1) begin
            start = 1'b1; wr_en = 1'b1; wr_addr = 2'd1; wr_data = 16'h7FFF;
         end
         if (i == lat) begin
            rdy_s = 1'b1; Out = val;
         end
         tick();
         start = 1'b0; wr_en = 1'b0; rdy_s = 1'b0; Out = 16'h0000;
      end
      if (last) begin
         chk("done_pulse", {15'd0, done}, 16'd1);
         chk("busy_done", {15'd0, busy}, 16'd0);
         chk("cs_done", {15'd0, cs_s}, 16'd0);
      end else begin
         chk("cs_gap", {15'd0, cs_s}, 16'd0);
         chk("busy_gap", {15'd0, busy}, 16'd1);
         chk("done_gap", {15'd0, done}, 16'd0);
         if (inj) begin
            rdy_s = 1'b1; Out = 16'hDEAD;
         end
         tick();
         rdy_s = 1'b0; Out = 16'h0000;
      end
   endtask

   task automatic read_chk(input string tag, input logic [1:0] a, input logic [15:0] exp);
      rd_addr = a;
      tick();
      chk(tag, rd_data, exp);
   endtask

   initial begin
      int n;
      rst = 1'b1; wr_en = 1'b0; start = 1'b0; rdy_s = 1'b0;
      wr_addr = '0; rd_addr = '0; wr_data = '0; Out = '0;
      tick(); tick();
      chk("rst_cs", {15'd0, cs_s}, 16'd0);
      chk("rst_busy", {15'd0, busy}, 16'd0);
      chk("rst_done", {15'd0, done}, 16'd0);
      chk("rst_err", {15'd0, err}, 16'd0);
      chk("rst_y", y, 16'h0000);
      chk("rst_rd", rd_data, 16'h0000);
      rst = 1'b0;

      // Normal 3-element run, 3-cycle responder latency
      load(2'd0, 16'hB900);
      load(2'd1, 16'h5000);
      load(2'd2, 16'hAC40);
      pulse_start();
      chk("busy_run", {15'd0, busy}, 16'd1);
      serve(3, 16'hB900, 16'h00B8, 1'b0, 1'b0);
      serve(3, 16'h5000, 16'h1000, 1'b0, 1'b0);
      serve(3, 16'hAC40, 16'h011E, 1'b1, 1'b0);
      chk("err_normal", {15'd0, err}, 16'd0);
      tick();
      chk("done_one_cycle", {15'd0, done}, 16'd0);
      read_chk("res0", 2'd0, 16'h00B8);
      read_chk("res1", 2'd1, 16'h1000);
      read_chk("res2", 2'd2, 16'h011E);

      // Timeout: responder silent
      pulse_start();
      n = 0;
      while (cs_s && n < 20) begin
         n++;
         tick();
      end
      chk("timeout_cs_cycles", 16'(n), 16'd8);
      chk("timeout_done", {15'd0, done}, 16'd1);
      chk("timeout_err", {15'd0, err}, 16'd1);
      tick();
      chk("err_sticky", {15'd0, err}, 16'd1);
      read_chk("timeout_res0", 2'd0, 16'h00B8);
      chk("err_sticky2", {15'd0, err}, 16'd1);

      // rdy_s on the final allowed REQ cycle
      pulse_start();
      chk("err_cleared", {15'd0, err}, 16'd0);
      serve(8, 16'hB900, 16'h0ABC, 1'b0, 1'b0);
      chk("edge_err", {15'd0, err}, 16'd0);
      serve(1, 16'h5000, 16'h0111, 1'b0, 1'b0);
      serve(1, 16'hAC40, 16'h0222, 1'b1, 1'b0);
      chk("edge_err_end", {15'd0, err}, 16'd0);
      tick();
      read_chk("edge_res0", 2'd0, 16'h0ABC);
      read_chk("edge_res2", 2'd2, 16'h0222);

      // Ignored start/wr_en mid-run and spurious rdy_s in GAP
      pulse_start();
      serve(3, 16'hB900, 16'h00B8, 1'b0, 1'b1);
      serve(3, 16'h5000, 16'h1000, 1'b0, 1'b1);
      serve(3, 16'hAC40, 16'h011E, 1'b1, 1'b0);
      tick();
      chk("no_restart", {15'd0, cs_s}, 16'd0);
      read_chk("ign_res0", 2'd0, 16'h00B8);
      read_chk("ign_res1", 2'd1, 16'h1000);
      read_chk("ign_res2", 2'd2, 16'h011E);

      // Reset during REQ of element 1, then a clean rerun
      pulse_start();
      serve(3, 16'hB900, 16'h0555, 1'b0, 1'b0);
      chk("pre_rst_y", y, 16'h5000);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_mid_cs", {15'd0, cs_s}, 16'd0);
      chk("rst_mid_busy", {15'd0, busy}, 16'd0);
      chk("rst_mid_done", {15'd0, done}, 16'd0);
      tick();
      chk("rst_mid_no_done", {15'd0, done}, 16'd0);
      pulse_start();
      serve(2, 16'hB900, 16'h00B8, 1'b0, 1'b0);
      serve(2, 16'h5000, 16'h1000, 1'b0, 1'b0);
      serve(2, 16'hAC40, 16'h011E, 1'b1, 1'b0);

      // Back-to-back: start during DONE ignored; start in IDLE with same-cycle write
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("b2b_ignored_cs", {15'd0, cs_s}, 16'd0);
      chk("b2b_ignored_busy", {15'd0, busy}, 16'd0);
      start = 1'b1; wr_en = 1'b1; wr_addr = 2'd0; wr_data = 16'h1234;
      tick();
      start = 1'b0; wr_en = 1'b0;
      serve(1, 16'h1234, 16'h0F00, 1'b0, 1'b0);
      serve(1, 16'h5000, 16'h0F01, 1'b0, 1'b0);
      serve(1, 16'hAC40, 16'h0F02, 1'b1, 1'b0);
      tick();
      read_chk("b2b_res0", 2'd0, 16'h0F00);
      read_chk("rst_rerun_res1", 2'd1, 16'h0F01);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
